// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and widths for the direct-mapped data cache
//
// Purpose: holds the controller state enum, the address split constants,
//          the memory-interface widths and a line-replication helper.
// Ports:   none (package).
package dcache_pkg;

  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int BE_W           = DATA_W / 8;
  localparam int OFFSET_W       = 4;
  localparam int WORD_SEL_W     = 2;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_W         = DATA_W * WORDS_PER_LINE;
  localparam int MEM_ADDR_W     = ADDR_W - OFFSET_W;
  localparam int MEM_MASK_W     = LINE_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    MISS_REQ,
    MISS_WAIT,
    MISS_RESP,
    WRITE
  } state_e;

  function automatic logic [LINE_W-1:0] replicate_word(input logic [DATA_W-1:0] w);
    return {WORDS_PER_LINE{w}};
  endfunction

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag/valid/data storage for the direct-mapped data cache
//
// Purpose: one line per index; combinational lookup, byte-masked word write,
//          full-line fill that also sets tag and valid. Valid bits clear on reset.
// Ports:   clk, reset (sync, active-high)
//          rd_idx_i -> rd_valid_o, rd_tag_o, rd_line_o   lookup
//          wr_en_i, wr_idx_i, wr_word_i, wr_data_i, wr_be_i   store hit update
//          fill_en_i, fill_idx_i, fill_tag_i, fill_data_i     miss refill
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = ADDR_W - OFFSET_W - IDX_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [LINE_W-1:0]     rd_line_o,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [WORD_SEL_W-1:0] wr_word_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic [BE_W-1:0]       wr_be_i,
  input  logic                  fill_en_i,
  input  logic [IDX_W-1:0]      fill_idx_i,
  input  logic [TAG_W-1:0]      fill_tag_i,
  input  logic [LINE_W-1:0]     fill_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_idx_i] <= 1'b1;
    end
  end

  // Tag and data carry no reset; valid_q alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_idx_i]  <= fill_tag_i;
      data_q[fill_idx_i] <= fill_data_i;
    end else if (wr_en_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be_i[b]) begin
          data_q[wr_idx_i][{wr_word_i, 5'(b * 8)} +: 8] <= wr_data_i[b*8 +: 8];
        end
      end
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped, write-through, no-write-allocate data cache
//
// Purpose: 16-byte lines, NUM_LINES entries. Read hits answer one cycle after
//          acceptance; read misses fetch the whole line; every store is sent
//          to memory as a single masked word inside a replicated 128-bit beat.
// Ports:   clk, reset (sync, active-high)
//          cpu_req_*  : request in (valid/ready, addr, data, byte mask; mask 0 = read)
//          cpu_resp_* : read response out
//          mem_req_*  : line-address request and write-data channels to memory
//          mem_resp_* : line fill from memory
//          hit_count, miss_count : present only when DCACHE_STATS_EN is defined
module dcache
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [ADDR_W-1:0]     cpu_req_addr,
  input  logic [DATA_W-1:0]     cpu_req_data,
  input  logic [BE_W-1:0]       cpu_req_write,
  output logic                  cpu_resp_valid,
  output logic [DATA_W-1:0]     cpu_resp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rw,
  output logic [MEM_ADDR_W-1:0] mem_req_addr,
  output logic                  mem_req_data_valid,
  input  logic                  mem_req_data_ready,
  output logic [LINE_W-1:0]     mem_req_data_bits,
  output logic [MEM_MASK_W-1:0] mem_req_data_mask,
  input  logic                  mem_resp_valid,
  input  logic [LINE_W-1:0]     mem_resp_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:2]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;

  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic                hit, is_write, accept;
  logic                arr_wr_en, fill_en;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_req_addr[1:0];

  // Lookup is always driven from the live CPU address; it only matters in IDLE.
  dcache_array #(.NUM_LINES(NUM_LINES)) u_array (
    .clk         (clk),
    .reset       (reset),
    .rd_idx_i    (cpu_req_addr[OFFSET_W +: IDX_W]),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .wr_en_i     (arr_wr_en),
    .wr_idx_i    (cpu_req_addr[OFFSET_W +: IDX_W]),
    .wr_word_i   (cpu_req_addr[3:2]),
    .wr_data_i   (cpu_req_data),
    .wr_be_i     (cpu_req_write),
    .fill_en_i   (fill_en),
    .fill_idx_i  (addr_q[OFFSET_W +: IDX_W]),
    .fill_tag_i  (addr_q[ADDR_W-1 -: TAG_W]),
    .fill_data_i (mem_resp_data)
  );

  assign hit      = rd_valid && (rd_tag == cpu_req_addr[ADDR_W-1 -: TAG_W]);
  assign is_write = |cpu_req_write;
  assign accept   = cpu_req_valid && (state_q == IDLE);

  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    be_d               = be_q;
    aw_done_d          = aw_done_q;
    w_done_d           = w_done_q;
    resp_valid_d       = 1'b0;
    resp_data_d        = resp_data_q;
    arr_wr_en          = 1'b0;
    fill_en            = 1'b0;
    mem_req_valid      = 1'b0;
    mem_req_data_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          addr_d  = cpu_req_addr[ADDR_W-1:2];
          wdata_d = cpu_req_data;
          be_d    = cpu_req_write;
          if (is_write) begin
            arr_wr_en = hit;
            state_d   = WRITE;
          end else if (hit) begin
            resp_valid_d = 1'b1;
            resp_data_d  = rd_line[{cpu_req_addr[3:2], 5'd0} +: DATA_W];
          end else begin
            state_d = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (mem_resp_valid) begin
          fill_en      = 1'b1;
          resp_valid_d = 1'b1;
          resp_data_d  = mem_resp_data[{addr_q[3:2], 5'd0} +: DATA_W];
          state_d      = MISS_RESP;
        end
      end
      MISS_RESP: begin
        state_d = IDLE;
      end
      WRITE: begin
        // Address and data channels complete independently, in either order.
        mem_req_valid      = !aw_done_q;
        mem_req_data_valid = !w_done_q;
        aw_done_d = aw_done_q || mem_req_ready;
        w_done_d  = w_done_q || mem_req_data_ready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign cpu_req_ready     = (state_q == IDLE);
  assign cpu_resp_valid    = resp_valid_q;
  assign cpu_resp_data     = resp_data_q;
  assign mem_req_rw        = (state_q == WRITE);
  assign mem_req_addr      = addr_q[ADDR_W-1:OFFSET_W];
  assign mem_req_data_bits = replicate_word(wdata_q);
  assign mem_req_data_mask = {{(MEM_MASK_W-BE_W){1'b0}}, be_q} << {addr_q[3:2], 2'b00};

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept && !is_write) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - directed scoreboard bench for the data cache
module tb_dcache;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req_valid;
  logic         cpu_req_ready;
  logic [31:0]  cpu_req_addr;
  logic [31:0]  cpu_req_data;
  logic [3:0]   cpu_req_write;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_data;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic         mem_req_data_valid;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  always #5 clk = ~clk;

  dcache #(.NUM_LINES(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .cpu_req_valid      (cpu_req_valid),
    .cpu_req_ready      (cpu_req_ready),
    .cpu_req_addr       (cpu_req_addr),
    .cpu_req_data       (cpu_req_data),
    .cpu_req_write      (cpu_req_write),
    .cpu_resp_valid     (cpu_resp_valid),
    .cpu_resp_data      (cpu_resp_data),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_rw         (mem_req_rw),
    .mem_req_addr       (mem_req_addr),
    .mem_req_data_valid (mem_req_data_valid),
    .mem_req_data_ready (mem_req_data_ready),
    .mem_req_data_bits  (mem_req_data_bits),
    .mem_req_data_mask  (mem_req_data_mask),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_data      (mem_resp_data)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count          (hit_count),
    .miss_count         (miss_count)
`endif
  );

  int          vectors    = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];

  localparam logic [127:0] LINE_A = {32'h44444444, 32'h33333333, 32'hDEADBEEF, 32'h11111111};
  localparam logic [127:0] LINE_B = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
  localparam logic [127:0] LINE_C = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hCAFEF00D, 32'hC0C0C0C0};
  localparam logic [127:0] JUNK   = {4{32'hBAADF00D}};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response must have been predicted, in order.
  always @(negedge clk) begin
    if (!reset && cpu_resp_valid) begin
      chk("resp_predicted", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("resp_data", cpu_resp_data, exp_q.pop_front());
    end
  end

  task automatic read_hit(input logic [31:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    cpu_req_valid = 1'b1; cpu_req_addr = addr; cpu_req_write = 4'h0;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    chk("hit_resp_valid", cpu_resp_valid, 1);
    chk("hit_no_mem_req", mem_req_valid, 0);
    chk("hit_stays_idle", cpu_req_ready, 1);
  endtask

  task automatic read_miss(input logic [31:0] addr, input logic [127:0] line, input logic [31:0] exp);
    exp_q.push_back(exp);
    cpu_req_valid = 1'b1; cpu_req_addr = addr; cpu_req_write = 4'h0;
    @(negedge clk);
    cpu_req_valid = 1'b0; cpu_req_addr = 32'hFFFF_FFF0;
    chk("miss_req_valid", mem_req_valid, 1);
    chk("miss_req_rw", mem_req_rw, 0);
    chk("miss_req_addr", mem_req_addr, addr[31:4]);
    chk("miss_not_ready", cpu_req_ready, 0);
    chk("miss_no_early_resp", cpu_resp_valid, 0);
    mem_resp_valid = 1'b1; mem_resp_data = JUNK;    // must be ignored outside MISS_WAIT
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("miss_req_held", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("miss_wait_no_req", mem_req_valid, 0);
    chk("miss_wait_no_resp", cpu_resp_valid, 0);
    mem_resp_valid = 1'b1; mem_resp_data = line;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("miss_resp_valid", cpu_resp_valid, 1);
    @(negedge clk);
    chk("miss_resp_one_cycle", cpu_resp_valid, 0);
    chk("miss_back_idle", cpu_req_ready, 1);
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                            input int da, input int dd);
    int n;
    logic [15:0] exp_mask;
    n = (da > dd) ? da : dd;
    exp_mask = 16'(mask) << (addr[3:2] * 4);
    cpu_req_valid = 1'b1; cpu_req_addr = addr; cpu_req_data = data; cpu_req_write = mask;
    @(negedge clk);
    cpu_req_valid = 1'b0; cpu_req_data = 32'h0; cpu_req_write = 4'h0;
    chk("wr_rw", mem_req_rw, 1);
    chk("wr_addr", mem_req_addr, addr[31:4]);
    chk("wr_bits", mem_req_data_bits, {4{data}});
    chk("wr_mask", mem_req_data_mask, exp_mask);
    for (int c = 0; c <= n; c++) begin
      mem_req_ready      = (c == da);
      mem_req_data_ready = (c == dd);
      chk("wr_busy", cpu_req_ready, 0);
      chk("wr_aw_valid", mem_req_valid, c <= da);
      chk("wr_w_valid", mem_req_data_valid, c <= dd);
      chk("wr_no_resp", cpu_resp_valid, 0);
      @(negedge clk);
    end
    mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
    chk("wr_done_idle", cpu_req_ready, 1);
    chk("wr_done_no_resp", cpu_resp_valid, 0);
  endtask

  initial begin
    reset = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_data = '0; cpu_req_write = '0;
    mem_req_ready = 1'b0; mem_req_data_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", cpu_resp_valid, 0);
    chk("rst_resp_data", cpu_resp_data, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_data_valid", mem_req_data_valid, 0);
    chk("rst_mem_addr", mem_req_addr, 0);
    chk("rst_mem_bits", mem_req_data_bits, 0);
    chk("rst_mem_mask", mem_req_data_mask, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_idle_ready", cpu_req_ready, 1);
`ifdef DCACHE_STATS_EN
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
`endif

    // Cold miss, then hits on the same line including back-to-back.
    read_miss(32'h0000_0104, LINE_A, 32'hDEADBEEF);
    read_hit(32'h0000_0104, 32'hDEADBEEF);
    read_hit(32'h0000_010C, 32'h44444444);
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'h33333333);
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h0000_0100; cpu_req_write = 4'h0;
    @(negedge clk);
    chk("b2b_first_valid", cpu_resp_valid, 1);
    chk("b2b_ready", cpu_req_ready, 1);
    cpu_req_addr = 32'h0000_0108;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    chk("b2b_second_valid", cpu_resp_valid, 1);
    @(negedge clk);
    chk("b2b_idle_no_resp", cpu_resp_valid, 0);

    // Write hits: partial mask on word 1, then full word with late data handshake.
    write_word(32'h0000_0106, 32'hABCD0000, 4'b1100, 0, 0);
    read_hit(32'h0000_0104, 32'hABCDBEEF);
    write_word(32'h0000_010C, 32'h5A5A5A5A, 4'b1111, 0, 3);
    read_hit(32'h0000_010C, 32'h5A5A5A5A);

    // Write miss on the same index: no allocate, resident line untouched.
    write_word(32'h0000_0208, 32'h77777777, 4'b0001, 2, 0);
    read_hit(32'h0000_0104, 32'hABCDBEEF);

    // Conflict: new tag replaces line, old address then misses.
    read_miss(32'h0000_1104, LINE_B, 32'h66666666);
    read_hit(32'h0000_1100, 32'h55555555);
    read_miss(32'h0000_0104, LINE_C, 32'hCAFEF00D);
    read_hit(32'h0000_0108, 32'hC2C2C2C2);

    // Reset while waiting for a fill aborts without a response.
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h0000_0340; cpu_req_write = 4'h0;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("abort_in_wait", mem_req_valid, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rst_resp", cpu_resp_valid, 0);
    chk("abort_rst_mem_req", mem_req_valid, 0);
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = LINE_B;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("abort_no_resp", cpu_resp_valid, 0);
    chk("abort_idle", cpu_req_ready, 1);
    @(negedge clk);
    chk("abort_no_resp_later", cpu_resp_valid, 0);
`ifdef DCACHE_STATS_EN
    chk("abort_hit_count", hit_count, 0);
    chk("abort_miss_count", miss_count, 0);
`endif
    read_miss(32'h0000_0104, LINE_A, 32'hDEADBEEF);
    read_miss(32'h0000_0340, LINE_B, 32'h55555555);
    read_hit(32'h0000_0104, 32'hDEADBEEF);
`ifdef DCACHE_STATS_EN
    chk("final_hit_count", hit_count, 1);
    chk("final_miss_count", miss_count, 2);
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16, line count; power of two, >= 2.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports cpu_req_valid in 1, cpu_req_ready out 1, cpu_req_addr in 32 (byte address), cpu_req_data in 32 (lane-aligned store data), cpu_req_write in 4 (byte mask; 0 = read).
REQ-005 SHALL have ports cpu_resp_valid out 1, cpu_resp_data out 32 (read data).
REQ-006 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_req_rw out 1 (1 = write), mem_req_addr out 28 (addr[31:4]).
REQ-007 SHALL have ports mem_req_data_valid out 1, mem_req_data_ready in 1, mem_req_data_bits out 128, mem_req_data_mask out 16.
REQ-008 SHALL have ports mem_resp_valid in 1, mem_resp_data in 128.

Function
REQ-009 SHALL be direct-mapped with 16-byte lines: offset addr[3:0], word addr[3:2], index next log2(NUM_LINES) bits, tag the remaining upper bits.
REQ-010 SHALL be write-through, no-write-allocate.
REQ-011 SHALL use FSM states IDLE, MISS_REQ, MISS_WAIT, MISS_RESP, WRITE.
REQ-012 SHALL drive cpu_req_ready=1 only in IDLE; a request is accepted when cpu_req_valid && cpu_req_ready.
REQ-013 Read hit: SHALL assert cpu_resp_valid with the addressed word exactly 1 cycle after acceptance, remaining in IDLE; back-to-back hits sustain 1 per cycle.
REQ-014 Read miss: SHALL go IDLE->MISS_REQ; hold mem_req_valid=1, rw=0, addr=line address until mem_req_ready.
REQ-015 SHALL then go MISS_REQ->MISS_WAIT; on mem_resp_valid write the line, set valid, set tag, go MISS_RESP.
REQ-016 In MISS_RESP, SHALL assert cpu_resp_valid for 1 cycle with the requested word from the fill, then return to IDLE.
REQ-017 Write (cpu_req_write != 0): SHALL on acceptance update cached bytes under mask if hit, leave the array untouched on miss, and go WRITE.
REQ-018 In WRITE, SHALL hold mem_req_valid (rw=1) and mem_req_data_valid independently until each has handshaken.
REQ-019 In WRITE, mem_req_data_bits SHALL replicate cpu_req_data into all four word lanes; mem_req_data_mask = cpu_req_write shifted to word lane addr[3:2].
REQ-020 SHALL return to IDLE the cycle after both handshakes complete, same-cycle completion included; no cpu_resp_valid for writes.
REQ-021 SHALL latch address/data/mask at acceptance; CPU inputs outside IDLE are ignored.
REQ-022 SHALL ignore mem_resp_valid outside MISS_WAIT.
REQ-023 SHALL keep cpu_resp_valid low in all cycles not named in REQ-013/REQ-016.

Reset
REQ-024 On reset, SHALL enter IDLE, clear all valid bits, drive cpu_resp_valid, mem_req_valid, mem_req_data_valid to 0, cpu_resp_data and mem_req_* data/addr to 0.
REQ-025 Reset mid-miss or mid-write SHALL abort the transaction with no CPU response; the next access to that line misses.

Configuration
REQ-026 With DCACHE_STATS_EN defined, SHALL add outputs hit_count and miss_count, 32 bits each, counting accepted read hits/misses, wrapping at 2^32, cleared by reset.
REQ-027 Without DCACHE_STATS_EN, those ports and counters SHALL not exist; behaviour is otherwise identical.

Structure
REQ-028 Package dcache_pkg SHALL hold the state enum, line/word/offset width constants and memory-interface widths.
REQ-029 Sub-module dcache_array SHALL hold tag/valid/data storage with a byte-masked word write and a full-line fill port.

Verification
REQ-030 Cold read 0x0000_0104 -> MISS_REQ, mem_req_addr=0x0000010; mem_resp_data word1=0xDEADBEEF -> cpu_resp_valid with 0xDEADBEEF the cycle after mem_resp_valid.
REQ-031 Repeat read 0x0000_0104 -> cpu_resp_valid next cycle with 0xDEADBEEF, no mem_req_valid.
REQ-032 Write 0x0000_0106 mask 4'b1100 data 0xABCD0000 -> mem_req_data_mask=16'h00C0; then read 0x0000_0104 -> 0xABCDBEEF.
REQ-033 Read 0x0000_1104 (same index, new tag) -> miss, refill, tag replaced; read 0x0000_0104 then misses.
REQ-034 Write with mem_req_ready 3 cycles before mem_req_data_ready -> cpu_req_ready stays 0 until the cycle after the data handshake.
REQ-035 Reset asserted in MISS_WAIT, then mem_resp_valid -> no cpu_resp_valid; re-read of that line misses; with DCACHE_STATS_EN, hit_count=miss_count=0 after reset.
